matdet_seq: RTL and testbench
=============================

Name: matdet_seq

Overview:
- Sequential, fully parametrised NxN determinant engine. It replaces the fixed-size combinational matdetK cofactor trees.
- Evaluates the Leibniz permutation sum, one permutation term per clock. Permutations are visited in Steinhaus–Johnson–Trotter (SJT) order, so the term sign simply toggles each step.
- Uses one shared N-input product datapath. Valid/ready on input and output; sits between the matrix source and navigation solver stages.

Parameters:
- DATA_WIDTH, 8, element and result width; all arithmetic is mod 2^DATA_WIDTH.
- N, 7, matrix dimension; legal range 2..8.
- MATRIX_SIZE, N*N, element count. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  matrix offered
- in_ready  out  1  engine idle, can accept
- a  in  MATRIX_SIZE*DATA_WIDTH  row-major matrix; element (r,c) at a[((r*N)+c)*DATA_WIDTH +: DATA_WIDTH]; (0,0) at LSBs
- out_valid  out  1  det valid
- out_ready  in  1  consumer accepts det
- det  out  DATA_WIDTH  determinant mod 2^DATA_WIDTH
- busy  out  1  high in RUN

Behaviour:
- Reset is asynchronous and active-low (rst_n), on a single clock (clk).
  - Reset forces state=IDLE, in_ready=1, out_valid=0, busy=0, det=0.
  - Accumulator, permutation, direction and counter registers are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, a is latched into the internal matrix register. The caller may change a afterwards.
  - On the same edge: perm=identity, all directions=left, sign=+1, acc=0, cnt=0, state goes to RUN.
- RUN:
  - One SJT step per cycle: acc += sign * prod over r of m[r][perm[r]].
  - The product is truncated to DATA_WIDTH after each multiply; the subtract on negative sign is mod 2^DATA_WIDTH.
  - Then the largest mobile element is swapped with its neighbour in its direction. All larger elements have their direction reversed, sign is inverted and cnt increments.
  - When cnt==N!-1, that term's accumulation completes on the same edge: det<=final acc, state goes to DONE.
  - Latency from the accept edge to out_valid high is exactly N! cycles (N=7: 5040; N=2: 2).
- DONE:
  - out_valid=1; det is held stable.
  - On out_valid&&out_ready the engine returns to IDLE. in_ready goes high the cycle after, so there is no same-cycle re-accept.
  - det holds its value after the handshake until the next result is written.
- in_ready is low in RUN and DONE; in_valid is ignored there.
- Reset asserted mid-RUN or in DONE aborts the computation immediately. No out_valid is produced for the aborted matrix.
- N! must be computed as a constant; the counter width is clog2(N!).

Optional Feature:
- Macro: MATDET_ZERO_ROW_SKIP_EN.
- When defined:
  - At accept, a combinational check flags any all-zero row of a.
  - If one is found, state goes straight to DONE with det=0. out_valid is high 1 cycle after the accept edge.
- When undefined:
  - No check is made; every matrix takes N! cycles.
  - The result is identical (0) either way.

Decomposition:
- Package matdet_pkg:
  - function factorial(n); function clog2.
  - State enum type (IDLE/RUN/DONE).
  - Localparam N_MAX=8.
- Sub-module sjt_perm_gen (params N):
  - Holds perm[N] indices and direction bits.
  - Ports: clk, rst_n, init, step, perm_flat out, sign out.
  - Purely combinational largest-mobile search plus registered update.
- Top-level matdet_seq contains:
  - The matrix register and the FSM.
  - A mux-select per row, an N-term multiply chain and the accumulator.

Test Plan:
- Identity, N=7, W=8: accept -> out_valid exactly 5040 cycles later, det=0x01.
- N=3, W=8, rows [2,0,1],[1,3,2],[1,1,2] -> det=6 after 6 cycles.
- N=2, [[0,1],[1,0]] -> det=0xFF (-1 mod 256). [[16,0],[0,16]] -> det=0x00 (256 wraps).
- Backpressure, N=3 matrix above with out_ready held low for 20 cycles:
  - out_valid stays 1 and det stays 6; in_valid pulses in that window are not accepted.
  - Raise out_ready -> handshake, then IDLE.
- Reset mid-RUN: drop rst_n at cycle 3 of an N=3 run.
  - All outputs go to reset values asynchronously (before the next edge).
  - A fresh matrix afterwards yields the correct det.
- With MATDET_ZERO_ROW_SKIP_EN, N=7 matrix with row 4 all zero:
  - det=0 with out_valid 1 cycle after accept.
  - Without the macro: det=0 after 5040 cycles.

Source files
------------

// File: rtl/matdet_pkg.sv
// Shared types and constant helpers for the sequential determinant engine.
package matdet_pkg;

  // Largest matrix dimension the engine is meant to be built for.
  localparam int N_MAX = 8;

  // Engine states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // n! evaluated at elaboration time; sizes the permutation counter.
  function automatic int factorial(input int n);
    int f;
    f = 1;
    for (int i = 2; i <= n; i++) begin
      f = f * i;
    end
    return f;
  endfunction

  // Ceiling log2 for elaboration-time widths (clog2(1) == 0).
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/matdet_seq_if.sv
// Handshake bundle between the matrix source, the determinant engine and
// the downstream consumer. The master side offers matrices and accepts
// results; the slave side is the engine.
interface matdet_seq_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 7
);

  logic                         in_valid;
  logic                         in_ready;
  logic [N*N*DATA_WIDTH-1:0]    a;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        det;
  logic                         busy;

  modport master (
    output in_valid,
    output a,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  det,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  a,
    input  out_ready,
    output in_ready,
    output out_valid,
    output det,
    output busy
  );

endinterface

// File: rtl/matdet_seq_sjt_perm_gen.sv
// Steinhaus-Johnson-Trotter permutation generator. Each step swaps the
// largest mobile element with the neighbour it points at, so consecutive
// permutations differ by one transposition and the parity simply toggles.
// Directions travel with their elements: 0 = pointing left, 1 = right.
module sjt_perm_gen
  import matdet_pkg::*;
#(
  parameter int N = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init,
  input  logic                     step,
  output logic [N*clog2(N)-1:0]    perm_flat,
  output logic                     sign
);

  localparam int IDX_W = clog2(N);

  logic [IDX_W-1:0] perm    [N];
  logic [IDX_W-1:0] perm_nx [N];
  logic             dir     [N];
  logic             dir_nx  [N];
  logic [N-1:0]     mobile;
  logic             found;
  logic             mob_dir;
  logic [IDX_W-1:0] mob_pos;
  logic [IDX_W-1:0] mob_val;
  logic [IDX_W-1:0] nb;

  // An element is mobile when the neighbour it points at holds a smaller value.
  for (genvar i = 0; i < N; i++) begin : g_mob
    if (i == 0) begin : g_first
      assign mobile[i] = dir[i] && (perm[i+1] < perm[i]);
    end else if (i == N - 1) begin : g_last
      assign mobile[i] = !dir[i] && (perm[i-1] < perm[i]);
    end else begin : g_mid
      assign mobile[i] = dir[i] ? (perm[i+1] < perm[i]) : (perm[i-1] < perm[i]);
    end
    assign perm_flat[i*IDX_W +: IDX_W] = perm[i];
  end

  // Locate the largest mobile element.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned; a missing default here would infer a latch.
    found   = 1'b0;
    mob_pos = '0;
    mob_val = '0;
    mob_dir = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (mobile[i] && (!found || (perm[i] > mob_val))) begin
        found   = 1'b1;
        mob_pos = IDX_W'(i);
        mob_val = perm[i];
        mob_dir = dir[i];
      end
    end
  end

  assign nb = mob_dir ? (mob_pos + 1'b1) : (mob_pos - 1'b1);

  // Build the next permutation: swap, then reverse every larger element.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      perm_nx[i] = perm[i];
      dir_nx[i]  = dir[i];
    end
    perm_nx[mob_pos] = perm[nb];
    perm_nx[nb]      = mob_val;
    dir_nx[mob_pos]  = dir[nb];
    dir_nx[nb]       = mob_dir;
    for (int i = 0; i < N; i++) begin
      if (perm_nx[i] > mob_val) begin
        dir_nx[i] = ~dir_nx[i];
      end
    end
  end

  // Permutation, direction and parity registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        perm[i] <= '0;
        dir[i]  <= 1'b0;
      end
      sign <= 1'b0;
    end else if (init) begin
      for (int i = 0; i < N; i++) begin
        perm[i] <= IDX_W'(i);
        dir[i]  <= 1'b0;
      end
      sign <= 1'b0;
    end else if (step && found) begin
      for (int i = 0; i < N; i++) begin
        perm[i] <= perm_nx[i];
        dir[i]  <= dir_nx[i];
      end
      sign <= ~sign;
    end
  end

endmodule

// File: rtl/matdet_seq.sv
// Sequential NxN determinant engine: accumulates one signed Leibniz term
// per clock, visiting permutations in SJT order so the term sign toggles
// every step. One matrix in flight; valid/ready on both sides.
// Optional build macro MATDET_ZERO_ROW_SKIP_EN: a matrix with an all-zero
// row is answered with det=0 straight from accept instead of running N! terms.
module matdet_seq
  import matdet_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 7
) (
  input logic         clk,
  input logic         rst_n,
  matdet_seq_if.slave bus
);

  localparam int MATRIX_SIZE = N * N;
  localparam int FACT        = factorial(N);
  localparam int CNT_W       = clog2(FACT);
  localparam int IDX_W       = clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FACT - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]                        state;
  logic [MATRIX_SIZE*DATA_WIDTH-1:0] a_in;
  logic [DATA_WIDTH-1:0]             m   [N][N];
  logic [DATA_WIDTH-1:0]             sel [N];
  logic [DATA_WIDTH-1:0]             term;
  logic [DATA_WIDTH-1:0]             acc;
  logic [DATA_WIDTH-1:0]             acc_nx;
  logic [DATA_WIDTH-1:0]             det_q;
  logic [CNT_W-1:0]                  cnt;
  logic [N*IDX_W-1:0]                perm_flat;
  logic                              sign;
  logic                              accept;
  logic                              step;
  logic                              skip;

  assign a_in   = bus.a;
  assign accept = bus.in_valid && (state == ST_IDLE);
  assign step   = (state == ST_RUN);

`ifdef MATDET_ZERO_ROW_SKIP_EN
  logic [N-1:0] row_zero;

  for (genvar r = 0; r < N; r++) begin : g_zero
    assign row_zero[r] = (a_in[r*N*DATA_WIDTH +: N*DATA_WIDTH] == '0);
  end
  assign skip = |row_zero;
`else
  assign skip = 1'b0;
`endif

  // Capture the offered matrix; the source is free to change a afterwards.
  // NOTE: the matrix store is deliberately not reset: it is only read in RUN,
  // and RUN is only ever entered through a fresh capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          m[r][c] <= a_in[((r*N)+c)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  sjt_perm_gen #(
    .N (N)
  ) u_perm (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (accept),
    .step      (step),
    .perm_flat (perm_flat),
    .sign      (sign)
  );

  // Per-row column select driven by the current permutation.
  for (genvar r = 0; r < N; r++) begin : g_sel
    assign sel[r] = m[r][perm_flat[r*IDX_W +: IDX_W]];
  end

  // N-term multiply chain, truncated to DATA_WIDTH after every multiply.
  always_comb begin
    // NOTE: blocking assignments chain the partial products within one
    // evaluation; state registers elsewhere use non-blocking only.
    term = sel[0];
    for (int r = 1; r < N; r++) begin
      term = term * sel[r];
    end
  end

  assign acc_nx = sign ? (acc - term) : (acc + term);

  // Control FSM, accumulator, term counter and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      det_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            acc <= '0;
            cnt <= '0;
            if (skip) begin
              det_q <= '0;
              state <= ST_DONE;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            det_q <= acc_nx;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state == ST_RUN);
  assign bus.det       = det_q;

endmodule

// File: tb/tb_matdet_seq.sv
// Self-checking bench for matdet_seq: three engines (N=7, N=3, N=2) share
// one clock and reset. Expected determinants are pushed to a queue at
// accept and popped when the engine raises out_valid.
module tb_matdet_seq;

  logic clk;
  logic rst_n;

  // Bench-side drive and observe, indexed 0:N=7, 1:N=3, 2:N=2.
  logic [415:0] a_drv [3];
  logic [2:0]   in_valid;
  logic [2:0]   out_ready;
  logic [2:0]   in_ready_o;
  logic [2:0]   out_valid_o;
  logic [2:0]   busy_o;
  logic [7:0]   det_o [3];

  logic [7:0]   mm [8][8];
  logic [7:0]   exp_q [$];
  int           n_tests;
  int           n_fail;

  matdet_seq_if #(.DATA_WIDTH(8), .N(7)) if7 ();
  matdet_seq_if #(.DATA_WIDTH(8), .N(3)) if3 ();
  matdet_seq_if #(.DATA_WIDTH(8), .N(2)) if2 ();

  matdet_seq #(.DATA_WIDTH(8), .N(7)) u_n7 (.clk(clk), .rst_n(rst_n), .bus(if7));
  matdet_seq #(.DATA_WIDTH(8), .N(3)) u_n3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  matdet_seq #(.DATA_WIDTH(8), .N(2)) u_n2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign if7.in_valid  = in_valid[0];
  assign if7.a         = a_drv[0][391:0];
  assign if7.out_ready = out_ready[0];
  assign if3.in_valid  = in_valid[1];
  assign if3.a         = a_drv[1][71:0];
  assign if3.out_ready = out_ready[1];
  assign if2.in_valid  = in_valid[2];
  assign if2.a         = a_drv[2][31:0];
  assign if2.out_ready = out_ready[2];

  assign in_ready_o  = {if2.in_ready,  if3.in_ready,  if7.in_ready};
  assign out_valid_o = {if2.out_valid, if3.out_valid, if7.out_valid};
  assign busy_o      = {if2.busy,      if3.busy,      if7.busy};
  assign det_o[0]    = if7.det;
  assign det_o[1]    = if3.det;
  assign det_o[2]    = if2.det;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [415:0] pack(input int n, input logic [7:0] src [8][8]);
    logic [415:0] f;
    f = '0;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        f[((r*n)+c)*8 +: 8] = src[r][c];
      end
    end
    return f;
  endfunction

  // Reference: Leibniz sum in lexicographic order, sign from inversion count.
  function automatic logic [7:0] det_model(input int n, input logic [7:0] src [8][8]);
    int         p [8];
    int         k;
    int         l;
    int         t;
    int         inv;
    int         i;
    int         j;
    bit         more;
    logic [7:0] acc;
    logic [7:0] prod;
    acc = '0;
    for (int q = 0; q < 8; q++) p[q] = q;
    more = 1'b1;
    while (more) begin
      prod = 8'd1;
      for (int r = 0; r < n; r++) prod = prod * src[r][p[r]];
      inv = 0;
      for (int x = 0; x < n; x++)
        for (int y = x + 1; y < n; y++)
          if (p[x] > p[y]) inv++;
      if (inv % 2 == 1) acc = acc - prod;
      else              acc = acc + prod;
      k = -1;
      for (int x = 0; x < n - 1; x++) if (p[x] < p[x+1]) k = x;
      if (k < 0) begin
        more = 1'b0;
      end else begin
        l = k + 1;
        for (int x = k + 1; x < n; x++) if (p[k] < p[x]) l = x;
        t = p[k]; p[k] = p[l]; p[l] = t;
        i = k + 1;
        j = n - 1;
        while (i < j) begin
          t = p[i]; p[i] = p[j]; p[j] = t;
          i++;
          j--;
        end
      end
    end
    return acc;
  endfunction

  task automatic clear_mm();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mm[r][c] = 8'd0;
  endtask

  task automatic random_mm(input int n);
    clear_mm();
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        mm[r][c] = 8'($urandom_range(0, 255));
  endtask

  task automatic scramble(input int id);
    for (int k = 0; k < 13; k++) a_drv[id][k*32 +: 32] = $urandom;
  endtask

  // Offer one matrix, check latency, optional backpressure window, det and release.
  task automatic run_one(input int id, input logic [415:0] flat, input logic [7:0] exp_det,
                         input int exp_lat, input int hold);
    int         w;
    int         lat;
    logic [7:0] want;
    w = 0;
    while (!in_ready_o[id] && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("idle_before_offer", in_ready_o[id], 1'b1);
    a_drv[id]    = flat;
    in_valid[id] = 1'b1;
    @(negedge clk);
    in_valid[id] = 1'b0;
    scramble(id);
    exp_q.push_back(exp_det);
    if (exp_lat > 0) begin
      check("busy_in_run", busy_o[id], 1'b1);
      check("in_ready_low_in_run", in_ready_o[id], 1'b0);
    end
    lat = 0;
    while (!out_valid_o[id] && lat < exp_lat + 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    for (int h = 0; h < hold; h++) begin
      check("hold_out_valid", out_valid_o[id], 1'b1);
      check("hold_det", det_o[id], want);
      in_valid[id] = h[0];
      scramble(id);
      @(negedge clk);
    end
    in_valid[id] = 1'b0;
    check("det", det_o[id], want);
    out_ready[id] = 1'b1;
    @(negedge clk);
    out_ready[id] = 1'b0;
    check("released_out_valid", out_valid_o[id], 1'b0);
    check("back_to_idle", in_ready_o[id], 1'b1);
    check("det_held_after_handshake", det_o[id], want);
  endtask

  initial begin
    bit seen;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    for (int i = 0; i < 3; i++) a_drv[i] = '0;

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", in_ready_o[i], 1'b1);
      check("rst_out_valid", out_valid_o[i], 1'b0);
      check("rst_busy", busy_o[i], 1'b0);
      check("rst_det", det_o[i], 8'h00);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Identity, N=7: det 1 after exactly 7! cycles.
    clear_mm();
    for (int r = 0; r < 7; r++) mm[r][r] = 8'd1;
    run_one(0, pack(7, mm), 8'h01, 5040, 0);

    // N=3 reference matrix with 20 cycles of backpressure.
    clear_mm();
    mm[0][0] = 8'd2; mm[0][1] = 8'd0; mm[0][2] = 8'd1;
    mm[1][0] = 8'd1; mm[1][1] = 8'd3; mm[1][2] = 8'd2;
    mm[2][0] = 8'd1; mm[2][1] = 8'd1; mm[2][2] = 8'd2;
    run_one(1, pack(3, mm), 8'd6, 6, 20);

    // Reset during the third RUN cycle of the same matrix.
    check("rst_test_idle", in_ready_o[1], 1'b1);
    a_drv[1]    = pack(3, mm);
    in_valid[1] = 1'b1;
    @(negedge clk);
    in_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", busy_o[1], 1'b1);
    check("pre_reset_det", det_o[1], 8'd6);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", in_ready_o[1], 1'b1);
    check("async_rst_out_valid", out_valid_o[1], 1'b0);
    check("async_rst_busy", busy_o[1], 1'b0);
    check("async_rst_det", det_o[1], 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid_o[1]) seen = 1'b1;
    end
    check("no_out_valid_after_abort", seen, 1'b0);

    // N=2 fixed cases: swap matrix and a wrapping diagonal.
    clear_mm();
    mm[0][1] = 8'd1; mm[1][0] = 8'd1;
    run_one(2, pack(2, mm), 8'hFF, 2, 0);
    clear_mm();
    mm[0][0] = 8'd16; mm[1][1] = 8'd16;
    run_one(2, pack(2, mm), 8'h00, 2, 0);

    // Random matrices against the reference model.
    for (int t = 0; t < 3; t++) begin
      random_mm(3);
      run_one(1, pack(3, mm), det_model(3, mm), 6, 0);
    end
    for (int t = 0; t < 3; t++) begin
      random_mm(2);
      run_one(2, pack(2, mm), det_model(2, mm), 2, 0);
    end

    // N=7 with row 4 all zero; with skip enabled out_valid is already up
    // during the first cycle after the accept edge.
    random_mm(7);
    for (int c = 0; c < 7; c++) mm[4][c] = 8'd0;
`ifdef MATDET_ZERO_ROW_SKIP_EN
    run_one(0, pack(7, mm), 8'h00, 0, 0);
`else
    run_one(0, pack(7, mm), 8'h00, 5040, 0);
`endif

    // One random N=7 matrix against the model.
    random_mm(7);
    run_one(0, pack(7, mm), det_model(7, mm), 5040, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
